// File: rtl/sensor_arbiter_if.sv
// -----------------------------------------------------------------------------
// sensor_arbiter_if
// Groups the requester-side and sensor-side signals of the sensor arbiter.
// Parameters : ID_W   - sensor ID width
//              DATA_W - sensor data width
// Signals    : REQ_I, ADDR0_I, ADDR1_I          requester requests / sensor IDs
//              GNT_O, DONE_O, DATA_O, ERR_O     grant, completion, read data, timeout
//              BUSY_O                           arbiter not idle
//              SENSOR_READ_EN_O, SENSOR_ADDR_O  read strobe / sensor ID to the port
//              SENSOR_DONE_I, SENSOR_DATA_I     completion strobe / data from the port
// Modports   : master - arbiter view (drives grants and the sensor strobe)
//              slave  - environment view (requesters plus sensor port)
// -----------------------------------------------------------------------------
interface sensor_arbiter_if #(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
);
   logic [1:0]        REQ_I;
   logic [ID_W-1:0]   ADDR0_I;
   logic [ID_W-1:0]   ADDR1_I;
   logic [1:0]        GNT_O;
   logic [1:0]        DONE_O;
   logic [DATA_W-1:0] DATA_O;
   logic              ERR_O;
   logic              BUSY_O;
   logic              SENSOR_READ_EN_O;
   logic [ID_W-1:0]   SENSOR_ADDR_O;
   logic              SENSOR_DONE_I;
   logic [DATA_W-1:0] SENSOR_DATA_I;

   modport master (
      input  REQ_I, ADDR0_I, ADDR1_I, SENSOR_DONE_I, SENSOR_DATA_I,
      output GNT_O, DONE_O, DATA_O, ERR_O, BUSY_O, SENSOR_READ_EN_O, SENSOR_ADDR_O
   );

   modport slave (
      output REQ_I, ADDR0_I, ADDR1_I, SENSOR_DONE_I, SENSOR_DATA_I,
      input  GNT_O, DONE_O, DATA_O, ERR_O, BUSY_O, SENSOR_READ_EN_O, SENSOR_ADDR_O
   );
endinterface

// File: rtl/sensor_arbiter.sv
// -----------------------------------------------------------------------------
// sensor_arbiter
// Two-requester round-robin arbiter in front of a single sensor read port.
// One transaction runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are
// registered and forced to zero by the asynchronous active-low reset.
// Parameters : ID_W, DATA_W, TIMEOUT (1..255, WAIT cycles before abort)
// Ports      : CLK_I  - clock, rising edge
//              RST_I  - asynchronous active-low reset
//              bus    - sensor_arbiter_if.master (requests, grants, sensor port)
// Option     : define SENSOR_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT
//              cycles with ERR_O; otherwise WAIT holds and ERR_O is 0.
// -----------------------------------------------------------------------------
module sensor_arbiter #(
   parameter int ID_W    = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   sensor_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
      $error("sensor_arbiter: TIMEOUT must be within 1..255");
   end

   state_t            r_state,    w_state_nxt;
   logic              r_last_gnt, w_last_gnt_nxt;  // index of requester served last
   logic [1:0]        r_gnt,      w_gnt_nxt;
   logic [1:0]        r_done,     w_done_nxt;
   logic [DATA_W-1:0] r_data,     w_data_nxt;
   logic              r_busy,     w_busy_nxt;
   logic              r_read_en,  w_read_en_nxt;
   logic [ID_W-1:0]   r_addr,     w_addr_nxt;
   logic              w_sel;

`ifdef SENSOR_ARB_TIMEOUT_EN
   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_err, w_err_nxt;
`endif

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      w_gnt_nxt      = r_gnt;
      w_done_nxt     = 2'b00;
      w_data_nxt     = {DATA_W{1'b0}};
      w_read_en_nxt  = 1'b0;
      w_addr_nxt     = r_addr;
      w_sel          = 1'b0;
`ifdef SENSOR_ARB_TIMEOUT_EN
      w_cnt_nxt      = r_cnt;
      w_err_nxt      = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.REQ_I != 2'b00) begin
               // On a tie the requester not served last wins.
               if (bus.REQ_I == 2'b11) begin
                  w_sel = ~r_last_gnt;
               end else begin
                  w_sel = bus.REQ_I[1];
               end
               w_gnt_nxt     = w_sel ? 2'b10 : 2'b01;
               w_addr_nxt    = w_sel ? bus.ADDR1_I : bus.ADDR0_I;
               w_read_en_nxt = 1'b1;
               w_state_nxt   = ST_ISSUE;
            end else begin
               w_gnt_nxt = 2'b00;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
`ifdef SENSOR_ARB_TIMEOUT_EN
            w_cnt_nxt   = 8'd0;
`endif
         end
         ST_WAIT: begin
            // A sensor strobe beats a simultaneous timeout.
            if (bus.SENSOR_DONE_I) begin
               w_done_nxt  = r_gnt;
               w_data_nxt  = bus.SENSOR_DATA_I;
               w_state_nxt = ST_RESP;
            end else begin
`ifdef SENSOR_ARB_TIMEOUT_EN
               if (r_cnt == C_TO_LAST) begin
                  w_done_nxt  = r_gnt;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
`else
               w_state_nxt = ST_WAIT;
`endif
            end
         end
         ST_RESP: begin
            w_last_gnt_nxt = r_gnt[1];
            w_gnt_nxt      = 2'b00;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_gnt_nxt   = 2'b00;
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State and registered-output flops.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
         r_gnt      <= 2'b00;
         r_done     <= 2'b00;
         r_data     <= {DATA_W{1'b0}};
         r_busy     <= 1'b0;
         r_read_en  <= 1'b0;
         r_addr     <= {ID_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         r_gnt      <= w_gnt_nxt;
         r_done     <= w_done_nxt;
         r_data     <= w_data_nxt;
         r_busy     <= w_busy_nxt;
         r_read_en  <= w_read_en_nxt;
         r_addr     <= w_addr_nxt;
      end
   end

`ifdef SENSOR_ARB_TIMEOUT_EN
   // WAIT-cycle counter and timeout flag.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_cnt <= 8'd0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= w_err_nxt;
      end
   end
   assign bus.ERR_O = r_err;
`else
   assign bus.ERR_O = 1'b0;
`endif

   assign bus.GNT_O            = r_gnt;
   assign bus.DONE_O           = r_done;
   assign bus.DATA_O           = r_data;
   assign bus.BUSY_O           = r_busy;
   assign bus.SENSOR_READ_EN_O = r_read_en;
   assign bus.SENSOR_ADDR_O    = r_addr;

endmodule

// File: tb/tb_sensor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sensor_arbiter
// Self-checking bench for sensor_arbiter. A transaction-level model (last
// winner plus the latency rules) predicts grants, strobes and completions.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sensor_arbiter;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   m_last;   // model: requester served most recently (1 after reset)

   sensor_arbiter_if #(.ID_W(8), .DATA_W(32)) bus ();

   sensor_arbiter #(.ID_W(8), .DATA_W(32), .TIMEOUT(10)) dut (
      .CLK_I (clk),
      .RST_I (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {GNT, DONE, ERR, BUSY, READ_EN, ADDR, DATA}
   function automatic logic [46:0] obs();
      return {bus.GNT_O, bus.DONE_O, bus.ERR_O, bus.BUSY_O, bus.SENSOR_READ_EN_O,
              bus.SENSOR_ADDR_O, bus.DATA_O};
   endfunction

   function automatic logic [46:0] expv(input logic [1:0] g, input logic [1:0] d,
                                        input logic e, input logic b, input logic r,
                                        input logic [7:0] a, input logic [31:0] dat);
      return {g, d, e, b, r, a, dat};
   endfunction

   // One full transaction; delay = WAIT cycles before the sensor strobe.
   task automatic run_txn(input logic [1:0] req, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [31:0] data, input int delay, input bit drop,
                          input bit early, input string name);
      int          win;
      logic [1:0]  eg;
      logic [7:0]  ea;
      logic [46:0] e;
      if (req == 2'b11) win = (m_last == 0) ? 1 : 0;
      else if (req == 2'b10) win = 1;
      else win = 0;
      eg = (win == 1) ? 2'b10 : 2'b01;
      ea = (win == 1) ? a1 : a0;
      bus.REQ_I = req; bus.ADDR0_I = a0; bus.ADDR1_I = a1;
      bus.SENSOR_DONE_I = 1'b0; bus.SENSOR_DATA_I = $urandom;
      @(negedge clk);
      e = expv(eg, 2'b00, 1'b0, 1'b1, 1'b1, ea, 32'd0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL %s issue: got %h want %h", name, obs(), e);
      end
      if (drop) begin
         bus.REQ_I = 2'b00; bus.ADDR0_I = ~a0; bus.ADDR1_I = ~a1;
      end
      if (early) begin
         bus.SENSOR_DONE_I = 1'b1; bus.SENSOR_DATA_I = ~data;
      end
      for (int i = 0; i <= delay; i++) begin
         @(negedge clk);
         bus.SENSOR_DONE_I = 1'b0;
         e = expv(eg, 2'b00, 1'b0, 1'b1, 1'b0, ea, 32'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s wait%0d: got %h want %h", name, i, obs(), e);
         end
         if (i == delay) begin
            bus.SENSOR_DONE_I = 1'b1; bus.SENSOR_DATA_I = data;
         end
      end
      @(negedge clk);
      bus.SENSOR_DONE_I = 1'b0; bus.SENSOR_DATA_I = $urandom;
      e = expv(eg, eg, 1'b0, 1'b1, 1'b0, ea, data);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL %s resp: got %h want %h", name, obs(), e);
      end
      m_last = win;
      @(negedge clk);
      e = expv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, ea, 32'd0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL %s idle: got %h want %h", name, obs(), e);
      end
   endtask

   task automatic test_reset();
      bus.REQ_I = 2'b00; bus.ADDR0_I = 8'd0; bus.ADDR1_I = 8'd0;
      bus.SENSOR_DONE_I = 1'b0; bus.SENSOR_DATA_I = 32'd0;
      rst_n = 1'b0;
      m_last = 1;
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", obs());
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs() !== 47'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h want 0", obs());
      end
   endtask

   task automatic test_contention();
      for (int k = 0; k < 4; k++)
         run_txn(2'b11, 8'h10 + 8'(k), 8'h20 + 8'(k), $urandom, 0, 1'b0, 1'b0, "contention");
      bus.REQ_I = 2'b00;
   endtask

   task automatic test_single();
      run_txn(2'b01, 8'h05, 8'h77, 32'hDEADBEEF, 2, 1'b1, 1'b0, "single");
   endtask

   task automatic test_early_strobe();
      run_txn(2'b10, 8'h01, 8'hA5, 32'h1234_5678, 3, 1'b1, 1'b1, "early_strobe");
   endtask

   task automatic test_drop_req();
      run_txn(2'b11, 8'h3C, 8'hC3, 32'hCAFE_F00D, 1, 1'b1, 1'b0, "drop_req");
   endtask

   task automatic test_reset_in_wait();
      bus.REQ_I = 2'b01; bus.ADDR0_I = 8'h42;
      @(negedge clk);   // ISSUE
      bus.REQ_I = 2'b00;
      @(negedge clk);   // WAIT
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs() !== 47'd0) begin
         n_fail++;
         $display("FAIL rst_wait_async: got %h want 0", obs());
      end
      m_last = 1;
      @(negedge clk);
      rst_n = 1'b1;
      bus.SENSOR_DONE_I = 1'b1; bus.SENSOR_DATA_I = 32'h5555_AAAA;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.SENSOR_DONE_I = 1'b0;
         n_tests++;
         if (obs() !== 47'd0) begin
            n_fail++;
            $display("FAIL rst_wait_late_done%0d: got %h want 0", i, obs());
         end
      end
      run_txn(2'b11, 8'h0A, 8'h0B, 32'h0BAD_F00D, 0, 1'b1, 1'b0, "post_reset_tie");
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++)
         run_txn(2'($urandom_range(3, 1)), 8'($urandom), 8'($urandom), $urandom,
                 int'($urandom_range(4, 0)), ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0), "random");
      bus.REQ_I = 2'b00;
   endtask

`ifdef SENSOR_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [46:0] e;
      // Strobe in the last allowed WAIT cycle still completes normally.
      run_txn(2'b01, 8'h66, 8'h99, 32'h0F0F_0F0F, 9, 1'b1, 1'b0, "timeout_tie");
      bus.REQ_I = 2'b10; bus.ADDR1_I = 8'hE1; bus.SENSOR_DONE_I = 1'b0;
      @(negedge clk);
      bus.REQ_I = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         e = expv(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 8'hE1, 32'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL timeout_wait%0d: got %h want %h", i, obs(), e);
         end
      end
      @(negedge clk);
      e = expv(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 8'hE1, 32'd0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL timeout_resp: got %h want %h", obs(), e);
      end
      m_last = 1;
      @(negedge clk);
      e = expv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'hE1, 32'd0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL timeout_idle: got %h want %h", obs(), e);
      end
   endtask
`else
   task automatic test_long_wait();
      // Without the timeout option WAIT outlasts any TIMEOUT value.
      run_txn(2'b10, 8'h11, 8'h22, 32'h8765_4321, 300, 1'b1, 1'b0, "long_wait");
   endtask
`endif

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_contention();
      test_single();
      test_early_strobe();
      test_drop_req();
      test_reset_in_wait();
      test_random();
`ifdef SENSOR_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
